// File: rtl/traffic_pkg.sv
// Shared encodings for the actuated intersection scheduler: 3-bit phase codes and lamp patterns.
// The FLASH code is reserved here; it is only reachable when TRAFFIC_FLASH_EN is defined.
package traffic_pkg;

  localparam logic [2:0] ST_NS_G  = 3'd0;
  localparam logic [2:0] ST_NS_Y  = 3'd1;
  localparam logic [2:0] ST_RED_A = 3'd2;
  localparam logic [2:0] ST_EW_G  = 3'd3;
  localparam logic [2:0] ST_EW_Y  = 3'd4;
  localparam logic [2:0] ST_RED_B = 3'd5;
  localparam logic [2:0] ST_WALK  = 3'd6;
  localparam logic [2:0] ST_FLASH = 3'd7;

  // Lamp bit order: {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk}
  localparam logic [6:0] LAMP_NS_G     = 7'b1000010;
  localparam logic [6:0] LAMP_NS_Y     = 7'b0100010;
  localparam logic [6:0] LAMP_EW_G     = 7'b0011000;
  localparam logic [6:0] LAMP_EW_Y     = 7'b0010100;
  localparam logic [6:0] LAMP_ALL_RED  = 7'b0010010;
  localparam logic [6:0] LAMP_WALK     = 7'b0010011;
  localparam logic [6:0] LAMP_FLASH_ON = 7'b0100010;
  localparam logic [6:0] LAMP_DARK     = 7'b0000000;

  function automatic logic is_green(input logic [2:0] s);
    return (s == ST_NS_G) || (s == ST_EW_G);
  endfunction

endpackage

// File: rtl/traffic_dwell_counter.sv
// Tick-gated dwell counter: clears on every phase change, saturates at SAT_GREEN while green
// and at all-ones otherwise so it can never wrap.
module traffic_dwell_counter #(
  parameter int CNT_W     = 4,
  parameter int SAT_GREEN = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             clear,
  input  logic             green,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] GREEN_MAX = CNT_W'(SAT_GREEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic at_limit;
  assign at_limit = (green && (count >= GREEN_MAX)) || (count == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick && !at_limit) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-driven intersection phase FSM with request latches and Moore lamp decode.
// Optional maintenance flash mode is compiled in with TRAFFIC_FLASH_EN.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN = 3,
  parameter int MAX_GREEN = 6,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 4,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ns_car,
  input  logic       ew_car,
  input  logic       ped_btn,
`ifdef TRAFFIC_FLASH_EN
  input  logic       flash_req,
`endif
  output logic       ns_g,
  output logic       ns_y,
  output logic       ns_r,
  output logic       ew_g,
  output logic       ew_y,
  output logic       ew_r,
  output logic       walk,
  output logic [2:0] phase
);

  localparam logic [CNT_W:0] MIN_G  = (CNT_W+1)'(MIN_GREEN);
  localparam logic [CNT_W:0] MAX_G  = (CNT_W+1)'(MAX_GREEN);
  localparam logic [CNT_W:0] YEL_E  = (CNT_W+1)'(YELLOW_T);
  localparam logic [CNT_W:0] RED_E  = (CNT_W+1)'(ALLRED_T);
  localparam logic [CNT_W:0] WALK_E = (CNT_W+1)'(WALK_T);

  logic [2:0]       state;
  logic [2:0]       next_state;
  logic [CNT_W-1:0] dwell_count;
  logic [CNT_W:0]   elapsed;
  logic             state_change;
  logic             ns_req;
  logic             ew_req;
  logic             ped_req;
  logic             last_dir;
  logic [6:0]       lamps;

  assign elapsed      = {1'b0, dwell_count} + 1'b1;
  assign state_change = (next_state != state);

  traffic_dwell_counter #(
    .CNT_W     (CNT_W),
    .SAT_GREEN (MAX_GREEN - 1)
  ) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .clear (state_change),
    .green (is_green(state)),
    .count (dwell_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_NS_G;
    end else begin
      state <= next_state;
    end
  end

  // A green yields only when the other side (or a pedestrian) waits and either
  // its own traffic has gone or it has used up its maximum green.
  always_comb begin
    next_state = state;
    case (state)
      ST_NS_G: begin
        if (tick && (elapsed >= MIN_G) && (ew_req || ped_req) &&
            (!ns_car || (elapsed >= MAX_G)))
          next_state = ST_NS_Y;
      end
      ST_NS_Y: begin
        if (tick && (elapsed == YEL_E)) next_state = ST_RED_A;
      end
      ST_RED_A: begin
        if (tick && (elapsed == RED_E)) next_state = ped_req ? ST_WALK : ST_EW_G;
      end
      ST_EW_G: begin
        if (tick && (elapsed >= MIN_G) && (ns_req || ped_req) &&
            (!ew_car || (elapsed >= MAX_G)))
          next_state = ST_EW_Y;
      end
      ST_EW_Y: begin
        if (tick && (elapsed == YEL_E)) next_state = ST_RED_B;
      end
      ST_RED_B: begin
        if (tick && (elapsed == RED_E)) next_state = ped_req ? ST_WALK : ST_NS_G;
      end
      ST_WALK: begin
        if (tick && (elapsed == WALK_E)) next_state = last_dir ? ST_NS_G : ST_EW_G;
      end
`ifdef TRAFFIC_FLASH_EN
      ST_FLASH: begin
        if (!flash_req) next_state = ST_RED_B;
      end
`endif
      default: next_state = ST_NS_G;
    endcase
`ifdef TRAFFIC_FLASH_EN
    if (flash_req) next_state = ST_FLASH;
`endif
  end

  // Requests latch on any clock; the clear on entry to the served phase wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      ns_req  <= 1'b0;
      ew_req  <= 1'b0;
      ped_req <= 1'b0;
    end else begin
      if (next_state == ST_NS_G && state != ST_NS_G) ns_req <= 1'b0;
      else if (ns_car && state != ST_NS_G)           ns_req <= 1'b1;

      if (next_state == ST_EW_G && state != ST_EW_G) ew_req <= 1'b0;
      else if (ew_car && state != ST_EW_G)           ew_req <= 1'b1;

      if (next_state == ST_WALK && state != ST_WALK) ped_req <= 1'b0;
      else if (ped_btn)                              ped_req <= 1'b1;
    end
  end

  // last_dir: 0 = WALK entered after NS traffic, 1 = after EW traffic.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_dir <= 1'b0;
    end else if (state == ST_RED_A && next_state == ST_WALK) begin
      last_dir <= 1'b0;
    end else if (state == ST_RED_B && next_state == ST_WALK) begin
      last_dir <= 1'b1;
    end
  end

`ifdef TRAFFIC_FLASH_EN
  logic blink;

  always_ff @(posedge clk) begin
    if (rst || state != ST_FLASH) begin
      blink <= 1'b1;
    end else if (tick) begin
      blink <= ~blink;
    end
  end
`endif

  always_comb begin
    lamps = LAMP_NS_G;
    case (state)
      ST_NS_G:  lamps = LAMP_NS_G;
      ST_NS_Y:  lamps = LAMP_NS_Y;
      ST_RED_A: lamps = LAMP_ALL_RED;
      ST_EW_G:  lamps = LAMP_EW_G;
      ST_EW_Y:  lamps = LAMP_EW_Y;
      ST_RED_B: lamps = LAMP_ALL_RED;
      ST_WALK:  lamps = LAMP_WALK;
`ifdef TRAFFIC_FLASH_EN
      ST_FLASH: lamps = blink ? LAMP_FLASH_ON : LAMP_DARK;
`endif
      default:  lamps = LAMP_NS_G;
    endcase
  end

  assign {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk} = lamps;
  assign phase = state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler; inputs change and outputs are sampled on negedge.
// Define TRAFFIC_FLASH_EN for both bench and RTL to include the flash-mode steps.
module tb_traffic_phase_scheduler;

  localparam logic [2:0] P_NS_G  = 3'd0;
  localparam logic [2:0] P_NS_Y  = 3'd1;
  localparam logic [2:0] P_RED_A = 3'd2;
  localparam logic [2:0] P_EW_G  = 3'd3;
  localparam logic [2:0] P_EW_Y  = 3'd4;
  localparam logic [2:0] P_RED_B = 3'd5;
  localparam logic [2:0] P_WALK  = 3'd6;

  // {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk}
  localparam logic [6:0] L_NSG  = 7'b1000010;
  localparam logic [6:0] L_NSY  = 7'b0100010;
  localparam logic [6:0] L_EWG  = 7'b0011000;
  localparam logic [6:0] L_EWY  = 7'b0010100;
  localparam logic [6:0] L_RED  = 7'b0010010;
  localparam logic [6:0] L_WALK = 7'b0010011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       ns_car = 1'b0;
  logic       ew_car = 1'b0;
  logic       ped_btn = 1'b0;
`ifdef TRAFFIC_FLASH_EN
  logic       flash_req = 1'b0;
`endif
  logic       ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk;
  logic [2:0] phase;
  logic [6:0] lamps_v;

  int total = 0;
  int bad   = 0;

  assign lamps_v = {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk};

  always #5 clk = ~clk;

  traffic_phase_scheduler dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .ns_car  (ns_car),
    .ew_car  (ew_car),
    .ped_btn (ped_btn),
`ifdef TRAFFIC_FLASH_EN
    .flash_req (flash_req),
`endif
    .ns_g    (ns_g),
    .ns_y    (ns_y),
    .ns_r    (ns_r),
    .ew_g    (ew_g),
    .ew_y    (ew_y),
    .ew_r    (ew_r),
    .walk    (walk),
    .phase   (phase)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_st(input string tag, input logic [2:0] exp_phase, input logic [6:0] exp_lamps);
    chk({tag, "_phase"}, {5'd0, phase}, {5'd0, exp_phase});
    chk({tag, "_lamps"}, {1'b0, lamps_v}, {1'b0, exp_lamps});
  endtask

  task automatic do_reset();
    rst = 1'b1; tick = 1'b0; ns_car = 1'b0; ew_car = 1'b0; ped_btn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic tk(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    do_reset();

    // Reset state and idle hold with no demand
    chk_st("reset", P_NS_G, L_NSG);
    chk("reset_cnt", {4'd0, dut.dwell_count}, 8'd0);
    chk("reset_reqs", {5'd0, dut.ns_req, dut.ew_req, dut.ped_req}, 8'd0);
    for (int i = 0; i < 20; i++) begin
      tk(1);
      chk_st("idle", P_NS_G, L_NSG);
    end

    // EW car pulse: 3 ticks NS_G, 2 NS_Y, 1 RED_A, then EW_G
    do_reset();
    ew_car = 1'b1;
    @(negedge clk);
    ew_car = 1'b0;
    chk("ew_req_set", {7'd0, dut.ew_req}, 8'd1);
    tk(2);
    chk_st("min_green_hold", P_NS_G, L_NSG);
    tk(1);
    chk_st("to_ns_y", P_NS_Y, L_NSY);
    tk(1);
    chk_st("ns_y_hold", P_NS_Y, L_NSY);
    tk(1);
    chk_st("to_red_a", P_RED_A, L_RED);
    tk(1);
    chk_st("to_ew_g", P_EW_G, L_EWG);
    chk("ew_req_clr", {7'd0, dut.ew_req}, 8'd0);
    tk(8);
    chk_st("ew_g_hold", P_EW_G, L_EWG);

    // Reset mid EW_Y, with tick, ped_btn and ew_car all active during reset
    ns_car = 1'b1;
    @(negedge clk);
    ns_car = 1'b0;
    tk(1);
    chk_st("to_ew_y", P_EW_Y, L_EWY);
    rst = 1'b1; tick = 1'b1; ped_btn = 1'b1; ew_car = 1'b1;
    @(negedge clk);
    rst = 1'b0; tick = 1'b0; ped_btn = 1'b0; ew_car = 1'b0;
    chk_st("mid_reset", P_NS_G, L_NSG);
    chk("mid_reset_cnt", {4'd0, dut.dwell_count}, 8'd0);
    chk("mid_reset_reqs", {4'd0, dut.ns_req, dut.ew_req, dut.ped_req, dut.last_dir}, 8'd0);

    // ns_car held with EW waiting: NS_G lasts MAX_GREEN ticks
    do_reset();
    ns_car = 1'b1; ew_car = 1'b1;
    @(negedge clk);
    ew_car = 1'b0;
    tk(5);
    chk_st("max_green_hold", P_NS_G, L_NSG);
    tk(1);
    chk_st("max_green_end", P_NS_Y, L_NSY);
    ns_car = 1'b0;

    // Pedestrian path after NS: RED_A -> WALK (4 ticks) -> EW_G
    do_reset();
    ped_btn = 1'b1;
    @(negedge clk);
    ped_btn = 1'b0;
    tk(3);
    chk_st("ped_ns_y", P_NS_Y, L_NSY);
    tk(3);
    chk_st("walk_a", P_WALK, L_WALK);
    chk("ped_req_clr", {7'd0, dut.ped_req}, 8'd0);
    tk(3);
    chk_st("walk_a_hold", P_WALK, L_WALK);
    tk(1);
    chk_st("walk_a_exit", P_EW_G, L_EWG);

    // Press on the WALK entry edge is absorbed
    do_reset();
    ped_btn = 1'b1;
    @(negedge clk);
    ped_btn = 1'b0;
    tk(5);
    chk_st("absorb_red_a", P_RED_A, L_RED);
    ped_btn = 1'b1; tick = 1'b1;
    @(negedge clk);
    ped_btn = 1'b0; tick = 1'b0;
    @(negedge clk);
    chk_st("absorb_walk", P_WALK, L_WALK);
    chk("absorb_ped_req", {7'd0, dut.ped_req}, 8'd0);
    tk(4);
    chk_st("absorb_ew_g", P_EW_G, L_EWG);
    tk(8);
    chk_st("absorb_no_rewalk", P_EW_G, L_EWG);

    // Pedestrian path after EW: saturated EW_G yields at once, RED_B -> WALK -> NS_G
    ped_btn = 1'b1;
    @(negedge clk);
    ped_btn = 1'b0;
    tk(1);
    chk_st("ped_ew_y", P_EW_Y, L_EWY);
    tk(2);
    chk_st("ped_red_b", P_RED_B, L_RED);
    tk(1);
    chk_st("walk_b", P_WALK, L_WALK);
    tk(4);
    chk_st("walk_b_exit", P_NS_G, L_NSG);

`ifdef TRAFFIC_FLASH_EN
    // Flash from EW_G, blink per tick, release to RED_B then NS_G
    do_reset();
    ew_car = 1'b1;
    @(negedge clk);
    ew_car = 1'b0;
    tk(6);
    chk_st("fl_pre", P_EW_G, L_EWG);
    flash_req = 1'b1;
    @(negedge clk);
    chk_st("fl_on", 3'd7, 7'b0100010);
    tk(1);
    chk_st("fl_off", 3'd7, 7'b0000000);
    tk(1);
    chk_st("fl_on2", 3'd7, 7'b0100010);
    flash_req = 1'b0;
    @(negedge clk);
    chk_st("fl_red_b", P_RED_B, L_RED);
    tk(1);
    chk_st("fl_ns_g", P_NS_G, L_NSG);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
Actuated intersection scheduler that shares the crossing between NS vehicles, EW vehicles and pedestrians.
- Upgrades the fixed-time light sequencer to demand-driven phase selection: min/max green, yellow, all-red clearance and an optional walk phase.
- Sits between the roadside sensor/button front end and the lamp drivers.
- Consumes the shared 1-cycle tick pulse from the tick generator.

Parameters:
MIN_GREEN, 3, minimum green duration in ticks (>=1)
MAX_GREEN, 6, maximum green duration in ticks while opposing demand is pending (>=MIN_GREEN)
YELLOW_T, 2, yellow duration in ticks (>=1)
ALLRED_T, 1, all-red clearance duration in ticks (>=1)
WALK_T, 4, pedestrian walk duration in ticks (>=1)
CNT_W, 4, dwell counter width; must hold max(all durations)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
tick  in  1  one-clk-cycle timing pulse
ns_car  in  1  NS vehicle sensor level
ew_car  in  1  EW vehicle sensor level
ped_btn  in  1  pedestrian button, any width
ns_g, ns_y, ns_r  out  1 each  NS lamps
ew_g, ew_y, ew_r  out  1 each  EW lamps
walk  out  1  pedestrian walk lamp
phase  out  3  current state encoding (debug/status)

Behaviour:
- States: NS_G, NS_Y, RED_A (after NS), EW_G, EW_Y, RED_B (after EW), WALK.
- Reset: state NS_G, dwell count 0, all request latches 0.
  - Outputs on reset: ns_g=1, ew_r=1, all other lamps 0, walk=0, phase=NS_G.
- Outputs are Moore, decoded from state only.
  - NS_G: ns_g, ew_r.
  - NS_Y: ns_y, ew_r.
  - EW_G: ew_g, ns_r.
  - EW_Y: ew_y, ns_r.
  - RED_A, RED_B, WALK: ns_r, ew_r.
  - WALK additionally drives walk=1.
  - Exactly one lamp per direction is lit in every state.
- Request latches (ns_req, ew_req, ped_req) sample every clk, not only on tick.
  - ns_req sets when ns_car=1 and state!=NS_G. It clears on entry to NS_G.
  - ew_req follows the same rule for EW_G.
  - ped_req sets on ped_btn=1 and clears on entry to WALK.
  - Clear wins when set and clear occur in the same cycle.
- Dwell counter advances only on tick. It resets to 0 on every state change.
  - elapsed = count+1 on the tick being evaluated.
  - The count saturates at MAX_GREEN-1 in green states; it never wraps.
- Transitions happen only on cycles with tick=1:
  - NS_G -> NS_Y when elapsed>=MIN_GREEN and (ew_req or ped_req) and (ns_car=0 or elapsed>=MAX_GREEN).
  - With no opposing demand, NS_G holds indefinitely.
  - NS_Y -> RED_A at elapsed==YELLOW_T.
  - RED_A at elapsed==ALLRED_T goes to WALK if ped_req, else EW_G.
  - EW_G, EW_Y and RED_B mirror NS_G, NS_Y and RED_A, using ns_req and ew_car.
  - WALK at elapsed==WALK_T goes to the green opposite the direction that preceded it: RED_A path -> EW_G, RED_B path -> NS_G. A 1-bit last_dir register records which path led into WALK.
- A tick during reset is ignored.
- Reset mid-operation returns to the reset state on the next edge, regardless of state.

Optional Feature:
Macro TRAFFIC_FLASH_EN.
- When defined: adds input port flash_req (1 bit) and state FLASH.
  - Any state enters FLASH on the next clk after flash_req=1. flash_req has priority over all timing.
  - In FLASH, ns_y and ew_r blink; a blink bit toggles on each tick, starting at 1.
  - All other lamps and walk are 0 in FLASH.
  - On flash_req=0, FLASH exits to RED_B. The normal sequence then resumes and leads to NS_G.
- When undefined: no port and no state; behaviour is exactly as above.

Decomposition:
- Shared package traffic_pkg holds:
  - state encoding localparams, 3-bit, including FLASH;
  - the lamp-pattern constants.
- One sub-module: traffic_dwell_counter (tick-gated, clear-on-transition, saturating counter, CNT_W wide).
- Request latches and the FSM stay in the top module.

Test Plan:
- Reset with no inputs, then 20 ticks -> remains NS_G; ns_g=1, ew_r=1 throughout.
- ew_car pulse for 1 clk during NS_G, ns_car=0 -> NS_G for 3 ticks, NS_Y for 2, RED_A for 1, then EW_G with ew_req cleared.
- ns_car held 1 and ew_req latched -> NS_G lasts exactly 6 ticks (MAX_GREEN), then NS_Y.
- ped_btn pulse during NS_G -> NS_Y -> RED_A -> WALK with walk=1 for 4 ticks -> EW_G; ped_req cleared on WALK entry.
- ped_btn pressed on the same clk WALK is entered -> press absorbed; no second WALK in the next cycle.
- rst asserted for 1 clk while in EW_Y -> next clk is NS_G, count 0, all latches 0.
- Flash (macro on): flash_req=1 in EW_G -> FLASH; ns_y toggles per tick; release -> RED_B, then NS_G.
